// File: rtl/uart_adder_pkg.sv
// uart_adder_pkg: shared encodings, constants and frame byte selection for the result UART
package uart_adder_pkg;
  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int FRAME_BYTES = 3;
  localparam logic UART_IDLE = 1'b1;
  typedef enum logic [1:0] {TOP_IDLE, TOP_SEND, TOP_DONE} top_state_t;
  typedef enum logic [1:0] {BYTE_IDLE, BYTE_START, BYTE_DATA, BYTE_STOP} byte_state_t;
  function automatic logic [7:0] frame_byte(input logic [1:0] i, input logic [15:0] s, input logic c);
    return i == 2'd0 ? {7'b0, c} : i == 2'd1 ? s[15:8] : s[7:0];
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser that can chain the next byte straight out of a stop bit
module uart_tx_byte
  import uart_adder_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       ready_o,
  output logic       byte_done_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  byte_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shreg, shreg_n;
  logic tx_n, wrap;
  assign wrap = cnt == LAST;
  assign byte_done_o = state == BYTE_STOP && wrap;
  assign ready_o = state == BYTE_IDLE || byte_done_o;
  // state, counters, shift register and the registered line
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= BYTE_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      tx_o <= UART_IDLE;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shreg <= shreg_n;
      tx_o <= tx_n;
    end
  end
  // next line level is decided one cycle ahead so tx_o stays a plain flop
  always_comb begin
    state_n = state;
    cnt_n = (state == BYTE_IDLE || wrap) ? '0 : cnt + 1'b1;
    bit_n = bit_idx;
    shreg_n = shreg;
    tx_n = tx_o;
    if (valid_i && ready_o) begin
      state_n = BYTE_START;
      cnt_n = '0;
      bit_n = '0;
      shreg_n = data_i;
      tx_n = 1'b0;
    end else if (wrap) begin
      case (state)
        BYTE_START: begin
          state_n = BYTE_DATA;
          tx_n = shreg[0];
        end
        BYTE_DATA: begin
          state_n = bit_idx == 3'd7 ? BYTE_STOP : BYTE_DATA;
          tx_n = bit_idx == 3'd7 ? UART_IDLE : shreg[1];
          shreg_n = shreg >> 1;
          bit_n = bit_idx + 3'd1;
        end
        BYTE_STOP: begin
          state_n = BYTE_IDLE;
          tx_n = UART_IDLE;
        end
        default: state_n = BYTE_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_result_tx.sv
// uart_result_tx: sends {cout}, sum[15:8], sum[7:0] as one back-to-back three-byte UART frame
module uart_result_tx
  import uart_adder_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] sum_i,
  input  logic        cout_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);
  top_state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [15:0] sum_q, sum_n;
  logic cout_q, cout_n, valid, ready, byte_done;
  logic [7:0] data;
  assign busy_o = state == TOP_SEND;
  assign done_o = state == TOP_DONE;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid), .data_i(data),
    .tx_o(tx_o), .ready_o(ready), .byte_done_o(byte_done)
  );
  // frame sequencer state and latched result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= TOP_IDLE;
      idx <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      sum_q <= sum_n;
      cout_q <= cout_n;
    end
  end
  // byte 0 is taken straight from the inputs on accept; later bytes come from the latch
  always_comb begin
    state_n = state;
    idx_n = idx;
    sum_n = sum_q;
    cout_n = cout_q;
    valid = 1'b0;
    data = frame_byte(2'd0, sum_i, cout_i);
    if (state == TOP_SEND) begin
      if (byte_done) begin
        state_n = idx == LAST_IDX ? TOP_DONE : TOP_SEND;
        idx_n = idx == LAST_IDX ? 2'd0 : idx + 2'd1;
        valid = idx != LAST_IDX;
        data = frame_byte(idx + 2'd1, sum_q, cout_q);
      end
    end else if (start_i && ready) begin
      state_n = TOP_SEND;
      idx_n = 2'd0;
      sum_n = sum_i;
      cout_n = cout_i;
      valid = 1'b1;
    end else if (state == TOP_DONE) begin
      state_n = TOP_IDLE;
    end
  end
endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx: directed scoreboard bench decoding the UART line cycle by cycle
module tb_uart_result_tx;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst, start, cout;
  logic [15:0] sum;
  logic tx, busy, done;
  int checks = 0, errors = 0;
  int cyc = 0, nsamp = 0, bytes_seen = 0, done_cnt = 0, done_cyc = -1;
  int fall_cyc = -1, busy_len = 0;
  logic busy_at_done = 1'b0;
  logic [39:0] wave = '0;
  logic [7:0] sb[$];

  uart_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sum_i(sum), .cout_i(cout),
    .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] make_wave(input logic [7:0] b);
    logic [39:0] w;
    w[3:0] = 4'h0;
    for (int k = 0; k < 8; k++) w[4+4*k +: 4] = {4{b[k]}};
    w[39:36] = 4'hF;
    return w;
  endfunction

  task automatic check_byte();
    logic [7:0] b;
    logic [39:0] exp_w;
    bytes_seen++;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL extra_byte got wave %h expected no byte", wave);
    end
    if (sb.size() != 0) begin
      b = sb.pop_front();
      exp_w = make_wave(b);
      checks++;
      assert (wave === exp_w) else begin
        errors++;
        $error("FAIL byte%0d got wave %h expected %h (byte %h)", bytes_seen, wave, exp_w, b);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (rst) nsamp = 0;
    else begin
      if (busy) busy_len++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (nsamp > 0 || tx == 1'b0) begin
        if (nsamp == 0 && fall_cyc < 0) fall_cyc = cyc;
        wave = {tx, wave[39:1]};
        nsamp++;
        if (nsamp == 40) begin
          nsamp = 0;
          check_byte();
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [15:0] s, input logic c);
    sum = s;
    cout = c;
    start = 1'b1;
    sb.push_back({7'b0, c});
    sb.push_back(s[15:8]);
    sb.push_back(s[7:0]);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) step();
    checks++;
    assert (done_cnt != d0) else begin
      errors++;
      $error("FAIL done_timeout got %0d pulses expected more than %0d", done_cnt, d0);
    end
  endtask

  initial begin
    int d0, b0;
    rst = 1'b1;
    start = 1'b0;
    sum = '0;
    cout = 1'b0;
    steps(3);
    checks += 3;
    assert (tx === 1'b1) else begin errors++; $error("FAIL rst_tx got %b expected 1", tx); end
    assert (busy === 1'b0) else begin errors++; $error("FAIL rst_busy got %b expected 0", busy); end
    assert (done === 1'b0) else begin errors++; $error("FAIL rst_done got %b expected 0", done); end
    rst = 1'b0;
    steps(2);

    fall_cyc = -1;
    busy_len = 0;
    send(16'hA5C3, 1'b1);
    wait_done(200);
    checks += 4;
    assert (done_cyc - fall_cyc == 120) else begin
      errors++; $error("FAIL done_latency got %0d expected 120", done_cyc - fall_cyc);
    end
    assert (busy_len == 120) else begin errors++; $error("FAIL busy_len got %0d expected 120", busy_len); end
    assert (busy_at_done === 1'b0) else begin errors++; $error("FAIL busy_at_done got %b expected 0", busy_at_done); end
    assert (bytes_seen == 3) else begin errors++; $error("FAIL bytes_a got %0d expected 3", bytes_seen); end
    steps(5);

    send(16'hFFFF, 1'b0);
    wait_done(200);
    steps(5);

    d0 = done_cnt;
    b0 = bytes_seen;
    send(16'h1234, 1'b0);
    steps(49);
    sum = 16'h5678;
    cout = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200);
    steps(150);
    checks += 3;
    assert (done_cnt - d0 == 1) else begin errors++; $error("FAIL drop_done got %0d expected 1", done_cnt - d0); end
    assert (bytes_seen - b0 == 3) else begin errors++; $error("FAIL drop_bytes got %0d expected 3", bytes_seen - b0); end
    assert (busy === 1'b0) else begin errors++; $error("FAIL drop_busy got %b expected 0", busy); end

    d0 = done_cnt;
    send(16'h3C5A, 1'b1);
    steps(55);
    #2 rst = 1'b1;
    #1;
    checks += 2;
    assert (tx === 1'b1) else begin errors++; $error("FAIL abort_tx got %b expected 1", tx); end
    assert (busy === 1'b0) else begin errors++; $error("FAIL abort_busy got %b expected 0", busy); end
    steps(2);
    sb.delete();
    rst = 1'b0;
    steps(150);
    checks += 2;
    assert (done_cnt == d0) else begin errors++; $error("FAIL abort_done got %0d expected %0d", done_cnt, d0); end
    assert (tx === 1'b1) else begin errors++; $error("FAIL abort_idle got %b expected 1", tx); end
    b0 = bytes_seen;
    send(16'h9E01, 1'b0);
    wait_done(200);
    steps(3);
    checks++;
    assert (bytes_seen - b0 == 3) else begin errors++; $error("FAIL post_rst_bytes got %0d expected 3", bytes_seen - b0); end

    d0 = done_cnt;
    b0 = bytes_seen;
    send(16'hBEEF, 1'b1);
    start = 1'b1;
    wait_done(200);
    sum = 16'h0F0F;
    cout = 1'b0;
    sb.push_back(8'h00);
    sb.push_back(8'h0F);
    sb.push_back(8'h0F);
    step();
    start = 1'b0;
    checks += 2;
    assert (tx === 1'b0) else begin errors++; $error("FAIL b2b_start got %b expected 0", tx); end
    assert (busy === 1'b1) else begin errors++; $error("FAIL b2b_busy got %b expected 1", busy); end
    wait_done(200);
    steps(5);
    checks += 3;
    assert (done_cnt - d0 == 2) else begin errors++; $error("FAIL b2b_done got %0d expected 2", done_cnt - d0); end
    assert (bytes_seen - b0 == 6) else begin errors++; $error("FAIL b2b_bytes got %0d expected 6", bytes_seen - b0); end
    assert (sb.size() == 0) else begin errors++; $error("FAIL b2b_left got %0d expected 0", sb.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
